// File: rtl/counter_pkg.sv
// Shared encodings and defaults for the counter command sequencer.
// Op and state codes are plain 2-bit constants so they match legacy drivers.
package counter_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_DEPTH = 4;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_STEP = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   function automatic logic is_step_op(input logic [1:0] op);
      return (op == OP_UP) || (op == OP_DOWN);
   endfunction

endpackage

// File: rtl/counter_cmd_fifo.sv
// Small synchronous command FIFO; the head entry is readable combinationally
// so the sequencer can pop it in the same cycle it first sees it.
module counter_cmd_fifo #(
   parameter int W     = 6,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wptr;
   logic [AW:0]  r_rptr;
   logic         w_do_push;
   logic         w_do_pop;

   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wptr[AW-1:0]] <= din;
      end
   end

   // Pointers carry one extra wrap bit to tell full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
         if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      end
   end

   assign empty = (r_wptr == r_rptr);
   assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign dout  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/counter_cmd_seq.sv
// Command sequencer driving an up/down counter that clears itself whenever
// it sees no strobe; idle cycles therefore reload the current count.
module counter_cmd_seq
   import counter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   input  logic [WIDTH-1:0] cnt_count,
   input  logic             cnt_high,
   input  logic             cnt_low,
   output logic             cnt_load,
   output logic             cnt_up,
   output logic             cnt_down,
   output logic [WIDTH-1:0] cnt_in,
   output logic             busy,
   output logic             done,
   output logic             sat
);

   logic [1:0]       r_state;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_rem;
   logic             r_sat;
   logic             r_init;

   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [WIDTH+1:0] w_head;
   logic [1:0]       w_head_op;
   logic [WIDTH-1:0] w_head_arg;
   logic             w_sat_hit;

   assign cmd_ready  = !w_full && r_init;
   assign w_push     = cmd_valid && cmd_ready;
   assign w_pop      = r_init && (r_state == S_IDLE) && !w_empty;
   assign w_head_op  = w_head[WIDTH+1:WIDTH];
   assign w_head_arg = w_head[WIDTH-1:0];
   assign busy       = (r_state != S_IDLE) || !w_empty;

   counter_cmd_fifo #(
      .W     (WIDTH + 2),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .din   ({cmd_op, cmd_arg}),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   // Checked against live counter feedback so a step can never wrap the count.
   always_comb begin
      w_sat_hit = 1'b0;
      if (r_op == OP_UP) begin
         w_sat_hit = cnt_high || (cnt_count == {WIDTH{1'b1}});
      end else if (r_op == OP_DOWN) begin
         w_sat_hit = cnt_low || (cnt_count == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_op    <= OP_NOP;
         r_rem   <= '0;
         r_sat   <= 1'b0;
         r_init  <= 1'b0;
      end else begin
         r_init <= 1'b1;
         if (r_init) begin
            case (r_state)
               S_IDLE: begin
                  if (!w_empty) begin
                     r_op  <= w_head_op;
                     r_rem <= w_head_arg;
                     r_sat <= 1'b0;
                     if (w_head_op == OP_LOAD) begin
                        r_state <= S_LOAD;
                     end else if (is_step_op(w_head_op) && (w_head_arg != '0)) begin
                        r_state <= S_STEP;
                     end else begin
                        r_state <= S_DONE;
                     end
                  end
               end
               S_LOAD: r_state <= S_DONE;
               S_STEP: begin
                  if (w_sat_hit) begin
                     r_sat   <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_rem <= r_rem - WIDTH'(1);
                     if (r_rem == WIDTH'(1)) r_state <= S_DONE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      cnt_load = 1'b0;
      cnt_up   = 1'b0;
      cnt_down = 1'b0;
      cnt_in   = '0;
      done     = 1'b0;
      sat      = 1'b0;
      if (r_init) begin
         case (r_state)
            S_LOAD: begin
               cnt_load = 1'b1;
               cnt_in   = r_rem;
            end
            S_STEP: begin
               if (w_sat_hit) begin
                  cnt_load = 1'b1;
                  cnt_in   = cnt_count;
               end else if (r_op == OP_UP) begin
                  cnt_up = 1'b1;
               end else begin
                  cnt_down = 1'b1;
               end
            end
            S_DONE: begin
               cnt_load = 1'b1;
               cnt_in   = cnt_count;
               done     = 1'b1;
               sat      = r_sat;
            end
            default: begin
               cnt_load = 1'b1;
               cnt_in   = cnt_count;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Bench for counter_cmd_seq with a behavioural self-clearing up/down counter
// attached; table of single commands plus FIFO-fill and mid-command reset cases.
`timescale 1ns/1ps
module tb_counter_cmd_seq;
   import counter_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_valid = 1'b0;
   logic [1:0]   cmd_op = 2'b00;
   logic [W-1:0] cmd_arg = '0;
   logic         cmd_ready;
   logic [W-1:0] cnt_count;
   logic         cnt_high, cnt_low;
   logic         cnt_load, cnt_up, cnt_down;
   logic [W-1:0] cnt_in;
   logic         busy, done, sat;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   counter_cmd_seq #(.WIDTH(W), .DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .cnt_count (cnt_count),
      .cnt_high  (cnt_high),
      .cnt_low   (cnt_low),
      .cnt_load  (cnt_load),
      .cnt_up    (cnt_up),
      .cnt_down  (cnt_down),
      .cnt_in    (cnt_in),
      .busy      (busy),
      .done      (done),
      .sat       (sat)
   );

   // Counter model: loads, steps, or clears to zero when no strobe is present.
   logic [W-1:0] model_cnt = 4'd9;
   always @(posedge clk) begin
      if (cnt_load)      model_cnt <= cnt_in;
      else if (cnt_up)   model_cnt <= model_cnt + 4'd1;
      else if (cnt_down) model_cnt <= model_cnt - 4'd1;
      else               model_cnt <= 4'd0;
   end
   assign cnt_count = model_cnt;
   assign cnt_high  = (model_cnt == 4'hF);
   assign cnt_low   = (model_cnt == 4'h0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [1:0] op, input logic [W-1:0] arg);
      int k;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      k = 0;
      while (!cmd_ready && k < 50) begin
         tick();
         k++;
      end
      if (!cmd_ready) check("push_timeout", 0, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] arg,
                          output int ups, output int downs, output int edges,
                          output logic sat_o, output logic [W-1:0] cnt_o, output logic got);
      ups = 0; downs = 0; edges = 0; sat_o = 1'b0; cnt_o = '0; got = 1'b0;
      push_cmd(op, arg);
      for (int k = 0; k < 60; k++) begin
         ups   += int'(cnt_up);
         downs += int'(cnt_down);
         if (done) begin
            got   = 1'b1;
            sat_o = sat;
            cnt_o = cnt_count;
            break;
         end
         tick();
         edges++;
      end
      if (!got) check("done_timeout", 0, 1);
   endtask

   typedef struct {
      logic [W-1:0] start;
      logic [1:0]   op;
      logic [W-1:0] arg;
      int           exp_cnt;
      int           exp_sat;
      int           exp_ups;
      int           exp_downs;
      int           exp_edges;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int ups, downs, edges, ndone;
      logic s, got;
      logic [W-1:0] c;
      logic [1:0] fill_op [5];
      logic [W-1:0] fill_arg [5];
      logic exp_fill_sat [5];
      logic got_sat [5];

      // start, op, arg, count, sat, ups, downs, edges from push to done
      vecs[0] = '{4'd14, OP_UP,   4'd3, 15, 1, 1, 0, 3};
      vecs[1] = '{4'd5,  OP_DOWN, 4'd2, 3,  0, 0, 2, 3};
      vecs[2] = '{4'd7,  OP_NOP,  4'd9, 7,  0, 0, 0, 1};
      vecs[3] = '{4'd7,  OP_UP,   4'd0, 7,  0, 0, 0, 1};
      vecs[4] = '{4'd1,  OP_DOWN, 4'd5, 0,  1, 0, 1, 3};
      vecs[5] = '{4'd3,  OP_UP,   4'd4, 7,  0, 4, 0, 5};
      vecs[6] = '{4'd15, OP_UP,   4'd1, 15, 1, 0, 0, 2};

      fill_op[0] = OP_UP;   fill_arg[0] = 4'd5;  exp_fill_sat[0] = 1'b0;
      fill_op[1] = OP_DOWN; fill_arg[1] = 4'd7;  exp_fill_sat[1] = 1'b1;
      fill_op[2] = OP_UP;   fill_arg[2] = 4'd2;  exp_fill_sat[2] = 1'b0;
      fill_op[3] = OP_UP;   fill_arg[3] = 4'd15; exp_fill_sat[3] = 1'b1;
      fill_op[4] = OP_DOWN; fill_arg[4] = 4'd3;  exp_fill_sat[4] = 1'b0;

      // Reset and init edge
      #1;
      check("rst_load", cnt_load, 0);
      check("rst_ready", cmd_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      check("init_strobes", {cnt_load, cnt_up, cnt_down}, 0);
      check("init_ready", cmd_ready, 0);
      tick();
      check("init_count", cnt_count, 0);
      check("init_low", cnt_low, 1);
      check("idle_load", cnt_load, 1);
      check("idle_in", cnt_in, 0);
      check("idle_ready", cmd_ready, 1);
      $display("reset release: count=%0d load=%0d ready=%0d", cnt_count, cnt_load, cmd_ready);

      // Table of single commands, each preceded by a LOAD of the start value
      for (int i = 0; i < 7; i++) begin
         run_cmd(OP_LOAD, vecs[i].start, ups, downs, edges, s, c, got);
         check("load_count", c, vecs[i].start);
         check("load_edges", edges, 2);
         run_cmd(vecs[i].op, vecs[i].arg, ups, downs, edges, s, c, got);
         check("vec_count", c, vecs[i].exp_cnt);
         check("vec_sat", s, vecs[i].exp_sat);
         check("vec_ups", ups, vecs[i].exp_ups);
         check("vec_downs", downs, vecs[i].exp_downs);
         check("vec_edges", edges, vecs[i].exp_edges);
         tick();
         check("done_one_cycle", done, 0);
         check("hold_count", cnt_count, vecs[i].exp_cnt);
         $display("vec %0d: start=%0d op=%0d arg=%0d -> count=%0d sat=%0d ups=%0d downs=%0d edges=%0d",
                  i, vecs[i].start, vecs[i].op, vecs[i].arg, c, s, ups, downs, edges);
      end

      // FIFO fill: queue five commands back-to-back behind a long UP
      run_cmd(OP_LOAD, 4'd0, ups, downs, edges, s, c, got);
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1;
         cmd_op    = fill_op[i];
         cmd_arg   = fill_arg[i];
         check("fill_ready", cmd_ready, 1);
         tick();
      end
      cmd_valid = 1'b0;
      check("full_ready", cmd_ready, 0);
      check("full_busy", busy, 1);
      ndone = 0;
      for (int k = 0; k < 200; k++) begin
         if (done) begin
            got_sat[ndone] = sat;
            ndone++;
            c = cnt_count;
         end
         if (ndone == 5) break;
         tick();
      end
      check("fill_ndone", ndone, 5);
      for (int i = 0; i < 5; i++) begin
         if (i < ndone) check("fill_sat", got_sat[i], exp_fill_sat[i]);
      end
      check("fill_count", c, 12);
      tick();
      check("fill_idle", busy, 0);
      $display("fifo fill: dones=%0d final count=%0d", ndone, c);

      // Reset in the middle of DOWN 8 with another command queued
      run_cmd(OP_LOAD, 4'd10, ups, downs, edges, s, c, got);
      push_cmd(OP_DOWN, 4'd8);
      push_cmd(OP_UP, 4'd1);
      tick();
      check("pre_rst_count", cnt_count, 9);
      rst_n = 1'b0;
      #1;
      check("arst_strobes", {cnt_load, cnt_up, cnt_down}, 0);
      check("arst_in", cnt_in, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_ready", cmd_ready, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("rerun_count", cnt_count, 0);
      check("rerun_busy", busy, 0);
      ndone = 0;
      for (int k = 0; k < 6; k++) begin
         ndone += int'(done);
         tick();
      end
      check("rerun_no_done", ndone, 0);
      check("rerun_hold", cnt_count, 0);
      $display("mid reset: count=%0d busy=%0d dones=%0d", cnt_count, busy, ndone);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
